uart_rx_console: RTL

- Synthesizable UART receiver that consumes the serial stream on the SoC's UART0 TX pin (RsTx_Sys0_SS0_S0).
- Replaces the behavioural console model on FPGA builds and gives benches a cycle-accurate byte stream.
- Deserializes 8N1 frames, checks framing, and buffers received bytes in a first-word-fall-through FIFO with a valid/ready output.
- Sits directly downstream of the UART TX pin; feeds an on-board console/LED driver or a bench checker.

---
 rtl/uart_rx_console.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_console.sv
// 8N1 UART receiver with first-word-fall-through byte FIFO for console capture.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_console #(
  parameter int BIT_CLKS   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          framing_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int CW = $clog2(BIT_CLKS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CLKS - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_e;

  state_e        state_q;
  logic          rx_m_q, rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          framing_err_q, overrun_q, parity_err_q;
  logic          par_bad;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          full, pop, push, stop_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;
  assign par_bad = par_bit_q ^ (^shift_q);
`else
  assign par_bad = 1'b0;
`endif

  assign full    = (level_q == LVL_FULL);
  assign pop     = rx_valid & rx_ready;
  assign stop_ok = (state_q == S_STOP) && (cnt_q == '0) && rx_s_q && !par_bad;
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign push    = stop_ok && (!full || pop);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rx_m_q        <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q     <= 1'b0;
`endif
    end else begin
      rx_m_q        <= rx;
      rx_s_q        <= rx_m_q;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      parity_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= HALF_M1;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rx_s_q) begin
            state_q <= S_DATA;
            cnt_q   <= FULL_M1;
            idx_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {rx_s_q, shift_q[7:1]};
            cnt_q   <= FULL_M1;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            par_bit_q <= rx_s_q;
            cnt_q     <= FULL_M1;
            state_q   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            parity_err_q <= par_bad;
            if (rx_s_q) begin
              overrun_q <= !par_bad && full && !pop;
              state_q   <= S_IDLE;
            end else begin
              framing_err_q <= 1'b1;
              state_q       <= S_WAIT_IDLE;
            end
          end
        end
        // Hold off until the line returns high so a break is not read as 0x00 frames.
        S_WAIT_IDLE: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_q] <= shift_q;
  end

  assign rx_valid    = (level_q != '0);
  assign rx_data     = rx_valid ? mem_q[rd_q] : 8'h00;
  assign fifo_level  = level_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;
  assign parity_err  = parity_err_q;

endmodule
